// File: rtl/xls_result_collector.sv
// Credit-based result collector for a fixed-latency, unreset XLS pipeline.
// Optional COLLECTOR_SEQ_TAG_EN adds an 8-bit per-result sequence tag (out_tag).
module xls_result_collector #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [WIDTH-1:0]         pipe_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
`ifdef COLLECTOR_SEQ_TAG_EN
    ,
    output logic [7:0]               out_tag
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] r_inflight;
    logic [LATENCY-1:0] w_inflight_next;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_drop_err;

    logic               w_accept;
    logic               w_land;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    logic [SW-1:0]      w_inflight_cnt;
    logic [SW-1:0]      w_occupancy;

    assign w_accept = issue_valid && issue_ready;
    assign w_land   = r_inflight[LATENCY-1];
    assign w_pop    = out_valid && out_ready;
    assign w_full   = (r_count == CW'(DEPTH));
    // A pop in the same edge frees the slot the landing result needs.
    assign w_write  = w_land && (!w_full || w_pop);

    genvar gi;
    assign w_inflight_next[0] = w_accept;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_shift
            assign w_inflight_next[gi] = r_inflight[gi-1];
        end
    endgenerate

    // Credits count every tracked result, including the one landing this cycle.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + SW'(r_inflight[i]);
        end
        w_occupancy = SW'(r_count) + w_inflight_cnt;
    end

    assign issue_ready = (w_occupancy < SW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_inflight <= w_inflight_next;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_land && w_full && !w_pop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= pipe_data;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign drop_err  = r_drop_err;

`ifdef COLLECTOR_SEQ_TAG_EN
    logic [7:0] r_tag_seq;
    logic [7:0] r_tag_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_seq <= '0;
        end else if (w_write) begin
            r_tag_seq <= r_tag_seq + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_tag_mem[r_wr_ptr] <= r_tag_seq;
        end
    end

    assign out_tag = out_valid ? r_tag_mem[r_rd_ptr] : '0;
`endif

endmodule
